dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

- Sequences every data-memory load and store issued by the MEM stage onto the word-wide synchronous data-memory port.
- Places store data and byte enables on the correct lanes.
- Splits misaligned accesses into two word transactions.
- Sign- or zero-extends loaded bytes and halfwords, and holds the pipeline stalled until the access completes.
- Sits between the MEM-stage pipeline register and the data-memory bank of the Harvard core.

## Interface
Parameters:
- MISALIGN_SPLIT, default 1: 1 = split misaligned accesses into two beats; 0 = reject them with rsp_err.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents an access.
- req_ready  out  1  high only in IDLE; an access is accepted on req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  1 = zero-extend a load (lbu/lhu); ignored for stores and words.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse marking completion of the accepted access.
- rsp_rdata  out  32  extended load data; valid with rsp_valid; 0 for stores.
- rsp_err  out  1  with rsp_valid: misaligned access rejected (MISALIGN_SPLIT=0 only).
- stall  out  1  equals ~req_ready; drives the pipeline hold.
- mem_req  out  1  memory request, held until granted.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  30  word address (byte address [31:2]).
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_rvalid  in  1  read data valid; one or more cycles after the grant of a read.
- mem_rdata  in  32  read word.

## Operation
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Accept in IDLE: register the request and move to REQ0.
  - If MISALIGN_SPLIT=0 and the access is misaligned, go straight to RESP with rsp_err=1; no memory traffic.
- Let o = addr[1:0] and n = 1, 2 or 4 bytes.
  - Build the 8-bit lane mask m = ((1<<n)-1) << o.
  - Build the 64-bit store image s = {32'b0, wdata masked to n bytes} << 8*o.
  - Beat 0: word A = addr[31:2], be = m[3:0], wdata = s[31:0].
  - Beat 1 exists iff m[7:4] != 0 (a misaligned half at o=3, or a word at o≠0). It uses word A+1 (30-bit wrap: 0x3FFFFFFF+1 = 0), be = m[7:4], wdata = s[63:32].
- REQ0 / REQ1:
  - Drive mem_req=1 with address, be, we and wdata held stable until mem_gnt.
  - On grant: a store goes to REQ1 (if beat 1 exists) or RESP; a load goes to WAIT0 / WAIT1.
- WAIT0 / WAIT1:
  - mem_req=0; capture mem_rdata on mem_rvalid.
  - Then go to REQ1 (if beat 1 exists) or RESP.
  - mem_rvalid seen outside WAIT states is ignored.
- Load assembly:
  - Form d = {beat1 word (0 if none), beat0 word} >> 8*o.
  - Keep the low n bytes.
  - Sign-extend from bit 8n-1 unless req_unsigned or n=4.
- RESP: rsp_valid=1 for one cycle with rsp_rdata / rsp_err, then IDLE.
- A new request can be accepted the cycle after RESP.
- Reset (any state, including mid-split): state returns to IDLE immediately.
  - Cleared: mem_req, rsp_valid, rsp_err, rsp_rdata and all captured data.
  - A half-completed split store is not rolled back.

## Timing
- Reset values:
  - req_ready=1, stall=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- All outputs come from registered state or registers; there is no combinational path from req_* to mem_*.
- Zero-wait memory means grant in the cycle of request and rvalid one cycle after grant. With accept at cycle T:
  - aligned store: mem_req T+1, rsp_valid T+2.
  - aligned load: mem_req T+1, rvalid T+2, rsp_valid T+3.
  - split store: beats at T+1, T+2; rsp_valid T+3.
  - split load: rsp_valid T+5.
  - rejected misaligned: rsp_valid T+1.
- Each cycle mem_gnt is low adds exactly one cycle, as does each cycle of mem_rvalid delay.
- At most one memory transaction is outstanding.

## Test plan
- Reset with X on all inputs, then deassert → req_ready=1, mem_req=0, all outputs at reset values; no rsp_valid.
- Store byte 0xA5 at 0x1003 (size 00) → mem_addr=0x400, be=1000, wdata=0xA5000000; rsp_valid at T+2.
- Load half at 0x2002, memory word 0x8001xxxx, signed, then unsigned → rsp_rdata=0xFFFF8001, then 0x00008001.
- Load word at 0x3001, words 0x44332211 / 0x88776655 → two beats, 0x0C00 be=1110 then 0x0C01 be=0001; rsp_rdata=0x55443322 at T+5.
- Store word at 0xFFFFFFFE, data 0xDEADBEEF → beat0 addr 0x3FFFFFFF be=1100 wdata=0xBEEF0000; beat1 addr 0 be=0011 wdata=0x0000DEAD. With mem_gnt held low 3 cycles on beat0, rsp_valid is delayed by exactly 3 cycles.
- MISALIGN_SPLIT=0, load word at 0x5: rsp_err=1 at T+1, no mem_req. Separately, assert rst_n low during WAIT1 of a split load: mem_req and stall drop immediately, and the next accepted request runs normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences MEM-stage loads and stores onto a word-wide data-memory port.
// Store data and byte enables are steered onto the correct lanes. Accesses
// that straddle a word boundary are split into two word beats, or rejected
// when MISALIGN_SPLIT is 0. Loaded bytes and halfwords are sign- or
// zero-extended. The pipeline is stalled whenever the block is not idle.
//
// Ports:
//   clk_i, rst_ni        core clock, asynchronous active-low reset
//   req_valid_i/ready_o  MEM-stage access handshake (ready only when idle)
//   req_we_i             1 = store, 0 = load
//   req_size_i           00 byte, 01 half, 10/11 word
//   req_unsigned_i       zero-extend loads (lbu/lhu)
//   req_addr_i           byte address
//   req_wdata_i          right-justified store data
//   rsp_valid_o          one-cycle completion pulse
//   rsp_rdata_o          extended load data (0 for stores)
//   rsp_err_o            misaligned access rejected (no-split build only)
//   stall_o              pipeline hold, the inverse of req_ready_o
//   mem_req_o/gnt_i      memory request, held until granted
//   mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o   memory command fields
//   mem_rvalid_i/rdata_i read data return

module dmem_access_ctrl #(
   parameter logic MISALIGN_SPLIT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        stall_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic        mem_we_o,
   output logic [29:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

   state_e      state_q, state_d;

   logic        we_q, uns_q, err_q;
   logic [1:0]  size_q, off_q;
   logic [3:0]  be1_q;
   logic [31:0] wdata1_q, rdata0_q, rdata1_q;
   logic        mem_we_q;
   logic [29:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;

   logic [7:0]  baseMask, laneMask;
   logic [31:0] dataMask;
   logic [63:0] storeImg;
   logic        misaligned, reject, accept, hasBeat1, startBeat1;
   logic [31:0] loadWord, loadExt;

   // Decode an incoming request into an 8-lane byte mask and a 64-bit store
   // image spanning two words; the upper halves describe the second beat.
   always_comb begin
      baseMask   = 8'h0F;
      dataMask   = 32'hFFFF_FFFF;
      misaligned = (req_addr_i[1:0] != 2'b00);
      case (req_size_i)
         2'b00: begin
            baseMask   = 8'h01;
            dataMask   = 32'h0000_00FF;
            misaligned = 1'b0;
         end
         2'b01: begin
            baseMask   = 8'h03;
            dataMask   = 32'h0000_FFFF;
            misaligned = req_addr_i[0];
         end
         default: ;
      endcase
      laneMask = baseMask << req_addr_i[1:0];
      storeImg = {32'b0, req_wdata_i & dataMask} << {req_addr_i[1:0], 3'b000};
      reject   = !MISALIGN_SPLIT && misaligned;
      accept   = (state_q == IDLE) && req_valid_i;
      hasBeat1 = (be1_q != 4'b0000);
   end

   // State register; reset abandons any access in flight, including the
   // second half of a split store.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Stores leave a REQ state on grant; loads wait for
   // read data before moving on to the next beat or the response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (req_valid_i) state_d = reject ? RESP : REQ0;
         REQ0:  if (mem_gnt_i) state_d = we_q ? (hasBeat1 ? REQ1 : RESP) : WAIT0;
         WAIT0: if (mem_rvalid_i) state_d = hasBeat1 ? REQ1 : RESP;
         REQ1:  if (mem_gnt_i) state_d = we_q ? RESP : WAIT1;
         WAIT1: if (mem_rvalid_i) state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      startBeat1 = (state_d == REQ1) && (state_q != REQ1);
   end

   // Request capture and memory command registers. Beat 0 is loaded at
   // accept so mem_* never depends combinationally on req_*; beat 1 reuses
   // the same registers with the next word address (wrapping at 30 bits).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= 2'b00;
         off_q       <= 2'b00;
         be1_q       <= 4'b0000;
         wdata1_q    <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= '0;
      end else begin
         if (accept) begin
            we_q     <= req_we_i;
            uns_q    <= req_unsigned_i;
            err_q    <= reject;
            size_q   <= req_size_i;
            off_q    <= req_addr_i[1:0];
            be1_q    <= laneMask[7:4];
            wdata1_q <= storeImg[63:32];
            rdata0_q <= '0;
            rdata1_q <= '0;
            if (!reject) begin
               mem_we_q    <= req_we_i;
               mem_addr_q  <= req_addr_i[31:2];
               mem_be_q    <= laneMask[3:0];
               mem_wdata_q <= storeImg[31:0];
            end
         end
         if (startBeat1) begin
            mem_addr_q  <= mem_addr_q + 30'd1;
            mem_be_q    <= be1_q;
            mem_wdata_q <= wdata1_q;
         end
         if ((state_q == WAIT0) && mem_rvalid_i) rdata0_q <= mem_rdata_i;
         if ((state_q == WAIT1) && mem_rvalid_i) rdata1_q <= mem_rdata_i;
      end
   end

   // Outputs decoded from state and registers. Load data is the two captured
   // words shifted down by the byte offset, then trimmed and extended.
   always_comb begin
      loadWord = 32'({rdata1_q, rdata0_q} >> {off_q, 3'b000});
      case (size_q)
         2'b00:   loadExt = {{24{!uns_q && loadWord[7]}}, loadWord[7:0]};
         2'b01:   loadExt = {{16{!uns_q && loadWord[15]}}, loadWord[15:0]};
         default: loadExt = loadWord;
      endcase
      req_ready_o = (state_q == IDLE);
      stall_o     = (state_q != IDLE);
      mem_req_o   = (state_q == REQ0) || (state_q == REQ1);
      rsp_valid_o = (state_q == RESP);
      rsp_err_o   = (state_q == RESP) && err_q;
      rsp_rdata_o = ((state_q == RESP) && !we_q && !err_q) ? loadExt : '0;
      mem_we_o    = mem_we_q;
      mem_addr_o  = mem_addr_q;
      mem_be_o    = mem_be_q;
      mem_wdata_o = mem_wdata_q;
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: a byte-level memory reference model plus a
// word-port memory responder with configurable grant and read-data delays.
// A second instance is built without split support to exercise rejection.

module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rstN;

   logic        reqValid, reqReady, reqWe, reqUnsigned;
   logic [1:0]  reqSize;
   logic [31:0] reqAddr, reqWdata;
   logic        rspValid, rspErr, stall;
   logic [31:0] rspRdata;
   logic        memReq, memGnt, memWe, memRvalid;
   logic [29:0] memAddr;
   logic [3:0]  memBe;
   logic [31:0] memWdata, memRdata;

   logic        nsReqValid, nsReqReady, nsReqWe, nsReqUnsigned;
   logic [1:0]  nsReqSize;
   logic [31:0] nsReqAddr, nsReqWdata;
   logic        nsRspValid, nsRspErr, nsStall;
   logic [31:0] nsRspRdata;
   logic        nsMemReq, nsMemGnt, nsMemWe, nsMemRvalid;
   logic [29:0] nsMemAddr;
   logic [3:0]  nsMemBe;
   logic [31:0] nsMemWdata, nsMemRdata;

   int numVectors = 0;
   int numMiscompares = 0;

   typedef struct packed {
      logic [29:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   logic [31:0] memArr [bit [29:0]];
   beat_t       beatLog[$];
   int          gntQ[$];
   int          rvQ[$];
   bit          respEn = 1'b0;
   bit          noiseEn = 1'b0;
   bit          nsRespEn = 1'b0;
   int          nsReqCount = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk_i(clk), .rst_ni(rstN),
      .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
      .req_size_i(reqSize), .req_unsigned_i(reqUnsigned), .req_addr_i(reqAddr),
      .req_wdata_i(reqWdata), .rsp_valid_o(rspValid), .rsp_rdata_o(rspRdata),
      .rsp_err_o(rspErr), .stall_o(stall), .mem_req_o(memReq), .mem_gnt_i(memGnt),
      .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_be_o(memBe),
      .mem_wdata_o(memWdata), .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata)
   );

   dmem_access_ctrl #(.MISALIGN_SPLIT(1'b0)) dutNs (
      .clk_i(clk), .rst_ni(rstN),
      .req_valid_i(nsReqValid), .req_ready_o(nsReqReady), .req_we_i(nsReqWe),
      .req_size_i(nsReqSize), .req_unsigned_i(nsReqUnsigned), .req_addr_i(nsReqAddr),
      .req_wdata_i(nsReqWdata), .rsp_valid_o(nsRspValid), .rsp_rdata_o(nsRspRdata),
      .rsp_err_o(nsRspErr), .stall_o(nsStall), .mem_req_o(nsMemReq), .mem_gnt_i(nsMemGnt),
      .mem_we_o(nsMemWe), .mem_addr_o(nsMemAddr), .mem_be_o(nsMemBe),
      .mem_wdata_o(nsMemWdata), .mem_rvalid_i(nsMemRvalid), .mem_rdata_i(nsMemRdata)
   );

   // Unwritten words hold a fixed scrambled pattern so every read is defined.
   function automatic logic [31:0] defWord(input logic [29:0] a);
      return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
   endfunction

   function automatic logic [31:0] memRead(input logic [29:0] a);
      if (memArr.exists(a)) return memArr[a];
      return defWord(a);
   endfunction

   function automatic logic [7:0] readByte(input logic [31:0] a);
      logic [31:0] w;
      w = memRead(a[31:2]);
      return w[8*a[1:0] +: 8];
   endfunction

   function automatic int nBytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   // Reference load: gather n little-endian bytes, then extend.
   function automatic logic [31:0] refLoad(input logic [31:0] addr, input int nb, input logic uns);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = readByte(addr + 32'(i));
      if (!uns && nb < 4 && v[8*nb-1]) begin
         for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Memory responder for the split-capable instance. It decides at each
   // falling edge whether the request seen now is granted at the next rising
   // edge, and returns read data after the queued delay.
   always @(negedge clk) begin : responder
      logic [31:0] w;
      static int gntWaitLeft = -1;
      static bit rdPending = 1'b0;
      static int rdDelay = 0;
      static logic [29:0] rdAddr = '0;
      if (!respEn) begin
         memGnt = 1'bx;
         memRvalid = 1'bx;
         memRdata = 'x;
      end else if (!rstN) begin
         rdPending = 1'b0;
         gntWaitLeft = -1;
         memGnt = 1'b0;
         memRvalid = 1'b0;
      end else begin
         memRvalid = 1'b0;
         memRdata = $urandom;
         if (rdPending) begin
            if (rdDelay == 0) begin
               memRvalid = 1'b1;
               memRdata = memRead(rdAddr);
               rdPending = 1'b0;
            end else begin
               rdDelay--;
            end
         end else if (noiseEn && $urandom_range(0, 3) == 0) begin
            memRvalid = 1'b1;
         end
         memGnt = 1'b0;
         if (memReq) begin
            if (gntWaitLeft < 0) gntWaitLeft = (gntQ.size() > 0) ? gntQ.pop_front() : 0;
            if (gntWaitLeft == 0) begin
               memGnt = 1'b1;
               gntWaitLeft = -1;
               beatLog.push_back('{memAddr, memBe, memWe, memWdata});
               if (memWe) begin
                  w = memRead(memAddr);
                  for (int i = 0; i < 4; i++) if (memBe[i]) w[8*i +: 8] = memWdata[8*i +: 8];
                  memArr[memAddr] = w;
               end else begin
                  rdPending = 1'b1;
                  rdAddr = memAddr;
                  rdDelay = (rvQ.size() > 0) ? rvQ.pop_front() : 0;
               end
            end else begin
               gntWaitLeft--;
            end
         end
      end
   end

   // Zero-wait responder for the no-split instance; every read returns a
   // fixed word.
   always @(negedge clk) begin : nsResponder
      static bit nsPend = 1'b0;
      if (!nsRespEn) begin
         nsMemGnt = 1'bx;
         nsMemRvalid = 1'bx;
         nsMemRdata = 'x;
      end else begin
         nsMemGnt = 1'b1;
         nsMemRvalid = nsPend;
         nsMemRdata = nsPend ? 32'hCAFE_F00D : $urandom;
         nsPend = nsMemReq && !nsMemWe && rstN;
         if (nsMemReq) nsReqCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numVectors++;
      if (observed !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkBeat(input string tag, input int idx, input logic [29:0] a,
                            input logic [3:0] be, input logic we, input logic [31:0] wd);
      if (idx < beatLog.size()) begin
         checkOutput({tag, "_addr"}, 32'(beatLog[idx].addr), 32'(a));
         checkOutput({tag, "_be"}, 32'(beatLog[idx].be), 32'(be));
         checkOutput({tag, "_we"}, 32'(beatLog[idx].we), 32'(we));
         checkOutput({tag, "_wdata"}, beatLog[idx].wdata, wd);
      end
   endtask

   // Issue one access and wait (bounded) for its response. Latency counts
   // cycles from the accepting edge to the cycle where rsp_valid is high.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output logic [31:0] rdata, output logic err);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!reqReady && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("req_ready", 32'(reqReady), 32'd1);
      reqValid = 1'b1;
      reqWe = we;
      reqSize = size;
      reqUnsigned = uns;
      reqAddr = addr;
      reqWdata = wdata;
      @(negedge clk);
      reqValid = 1'b0;
      reqWe = 1'($urandom);
      reqSize = 2'($urandom);
      reqUnsigned = 1'($urandom);
      reqAddr = $urandom;
      reqWdata = $urandom;
      lat = 1;
      while (!rspValid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      rdata = rspRdata;
      err = rspErr;
      if (!rspValid) begin
         checkOutput("rsp_timeout", 32'(rspValid), 32'd1);
      end else begin
         checkOutput("stall_in_resp", 32'(stall), 32'd1);
         @(negedge clk);
         checkOutput("rsp_pulse", 32'({rspValid, reqReady}), 32'b01);
      end
   endtask

   task automatic applyNs(input logic [1:0] size, input logic [31:0] addr,
                          output int lat, output logic [31:0] rdata, output logic err);
      @(negedge clk);
      nsReqValid = 1'b1;
      nsReqWe = 1'b0;
      nsReqSize = size;
      nsReqUnsigned = 1'b0;
      nsReqAddr = addr;
      nsReqWdata = $urandom;
      @(negedge clk);
      nsReqValid = 1'b0;
      lat = 1;
      while (!nsRspValid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("ns_rsp_seen", 32'(nsRspValid), 32'd1);
      rdata = nsRspRdata;
      err = nsRspErr;
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: observed no completion, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int lat, expLat, nb, beats, g, r, reqsBefore;
      logic [31:0] got, expRd, addr, wd;
      logic err, we, uns;
      logic [1:0] sz;
      logic [7:0] expB [6];

      // Reset with unknown inputs.
      rstN = 1'b0;
      {reqValid, reqWe, reqUnsigned, reqSize, reqAddr, reqWdata} = 'x;
      {nsReqValid, nsReqWe, nsReqUnsigned, nsReqSize, nsReqAddr, nsReqWdata} = 'x;
      #22;
      checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
      checkOutput("rst_rsp_rdata", rspRdata, 32'd0);
      checkOutput("rst_mem_req", 32'(memReq), 32'd0);
      checkOutput("rst_mem_we", 32'(memWe), 32'd0);
      checkOutput("rst_mem_be", 32'(memBe), 32'd0);
      checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
      checkOutput("rst_mem_wdata", memWdata, 32'd0);
      @(negedge clk);
      reqValid = 1'b0; reqWe = 1'b0; reqUnsigned = 1'b0; reqSize = 2'b00;
      reqAddr = '0; reqWdata = '0;
      nsReqValid = 1'b0; nsReqWe = 1'b0; nsReqUnsigned = 1'b0; nsReqSize = 2'b00;
      nsReqAddr = '0; nsReqWdata = '0;
      respEn = 1'b1;
      nsRespEn = 1'b1;
      rstN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("idle_after_rst", 32'({rspValid, memReq, reqReady}), 32'b001);
      end

      // Byte store at 0x1003 with junk in the unused data bits.
      beatLog.delete();
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h1234_56A5, lat, got, err);
      checkOutput("sb_lat", 32'(lat), 32'd2);
      checkOutput("sb_nbeats", 32'(beatLog.size()), 32'd1);
      checkBeat("sb_b0", 0, 30'h400, 4'b1000, 1'b1, 32'hA500_0000);
      checkOutput("sb_rdata", got, 32'd0);
      checkOutput("sb_mem", 32'(readByte(32'h1003)), 32'hA5);

      // Halfword loads at 0x2002, signed then unsigned.
      memArr[30'h800] = 32'h8001_1234;
      beatLog.delete();
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, lat, got, err);
      checkOutput("lh_lat", 32'(lat), 32'd3);
      checkOutput("lh_rdata", got, 32'hFFFF_8001);
      checkBeat("lh_b0", 0, 30'h800, 4'b1100, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, lat, got, err);
      checkOutput("lhu_rdata", got, 32'h0000_8001);

      // Split word load at 0x3001.
      memArr[30'hC00] = 32'h4433_2211;
      memArr[30'hC01] = 32'h8877_6655;
      beatLog.delete();
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, lat, got, err);
      checkOutput("lw_split_nbeats", 32'(beatLog.size()), 32'd2);
      checkBeat("lw_split_b0", 0, 30'hC00, 4'b1110, 1'b0, 32'h0);
      checkBeat("lw_split_b1", 1, 30'hC01, 4'b0001, 1'b0, 32'h0);
      checkOutput("lw_split_lat", 32'(lat), 32'd5);
      checkOutput("lw_split_rdata", got, 32'h5544_3322);

      // Split word store wrapping the address space, beat 0 grant held off 3 cycles.
      beatLog.delete();
      gntQ.push_back(3);
      gntQ.push_back(0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hDEAD_BEEF, lat, got, err);
      checkOutput("sw_wrap_nbeats", 32'(beatLog.size()), 32'd2);
      checkBeat("sw_wrap_b0", 0, 30'h3FFF_FFFF, 4'b1100, 1'b1, 32'hBEEF_0000);
      checkBeat("sw_wrap_b1", 1, 30'h0, 4'b0011, 1'b1, 32'h0000_DEAD);
      checkOutput("sw_wrap_lat", 32'(lat), 32'd6);

      // No-split instance: misaligned accesses rejected without memory traffic.
      reqsBefore = nsReqCount;
      applyNs(2'b10, 32'h0000_0005, lat, got, err);
      checkOutput("ns_lw5_err", 32'(err), 32'd1);
      checkOutput("ns_lw5_lat", 32'(lat), 32'd1);
      applyNs(2'b01, 32'h0000_0003, lat, got, err);
      checkOutput("ns_lh3_err", 32'(err), 32'd1);
      checkOutput("ns_no_mem_req", 32'(nsReqCount - reqsBefore), 32'd0);
      applyNs(2'b10, 32'h0000_0008, lat, got, err);
      checkOutput("ns_lw8_err", 32'(err), 32'd0);
      checkOutput("ns_lw8_lat", 32'(lat), 32'd3);
      checkOutput("ns_lw8_rdata", got, 32'hCAFE_F00D);
      applyNs(2'b01, 32'h0000_0006, lat, got, err);
      checkOutput("ns_lh6_rdata", got, 32'hFFFF_CAFE);

      // Reset asserted while waiting on beat-1 read data of a split load.
      gntQ.push_back(0);
      gntQ.push_back(0);
      rvQ.push_back(0);
      rvQ.push_back(12);
      @(negedge clk);
      reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0;
      reqAddr = 32'h0000_7001;
      @(negedge clk);
      reqValid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("wait1_stall", 32'(stall), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("midrst_stall", 32'(stall), 32'd0);
      checkOutput("midrst_mem_req", 32'(memReq), 32'd0);
      checkOutput("midrst_ready", 32'(reqReady), 32'd1);
      checkOutput("midrst_mem_addr", 32'(memAddr), 32'd0);
      checkOutput("midrst_mem_be", 32'(memBe), 32'd0);
      checkOutput("midrst_rdata", rspRdata, 32'd0);
      repeat (2) @(negedge clk);
      gntQ.delete();
      rvQ.delete();
      rstN = 1'b1;
      memArr[30'h900] = 32'h0000_00F0;
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_2400, 32'h0, lat, got, err);
      checkOutput("postrst_lb_lat", 32'(lat), 32'd3);
      checkOutput("postrst_lb_rdata", got, 32'hFFFF_FFF0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_2404, 32'h0BAD_CAFE, lat, got, err);
      checkOutput("postrst_sw_lat", 32'(lat), 32'd2);
      checkOutput("postrst_sw_mem", memRead(30'h901), 32'h0BAD_CAFE);

      // Randomized accesses with random grant/rvalid delays and stray rvalid.
      noiseEn = 1'b1;
      for (int t = 0; t < 200; t++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 255));
         wd = $urandom;
         nb = nBytes(sz);
         beats = (int'(addr[1:0]) + nb > 4) ? 2 : 1;
         expLat = 1;
         for (int b = 0; b < beats; b++) begin
            g = $urandom_range(0, 2);
            gntQ.push_back(g);
            expLat += g + 1;
            if (!we) begin
               r = $urandom_range(0, 2);
               rvQ.push_back(r);
               expLat += r + 1;
            end
         end
         expRd = '0;
         for (int k = 0; k < 6; k++) begin
            expB[k] = (k >= 1 && k <= nb) ? wd[8*(k-1) +: 8] : readByte(addr + 32'(k) - 32'd1);
         end
         if (!we) expRd = refLoad(addr, nb, uns);
         applyStimulus(we, sz, uns, addr, wd, lat, got, err);
         checkOutput("rnd_lat", 32'(lat), 32'(expLat));
         checkOutput("rnd_err", 32'(err), 32'd0);
         if (we) begin
            checkOutput("rnd_st_rdata", got, 32'd0);
            for (int k = 0; k < 6; k++) begin
               checkOutput("rnd_st_byte", 32'(readByte(addr + 32'(k) - 32'd1)), 32'(expB[k]));
            end
         end else begin
            checkOutput("rnd_ld_rdata", got, expRd);
         end
      end
      noiseEn = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
